// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: A - B - bin computed one 4-bit lookahead slice per clock, LS nibble first.
// Optional SUB_STATUS_FLAGS_EN adds registered zero/neg/ovf status outputs.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_STATUS_FLAGS_EN
    output logic             zero,
    output logic             neg,
    output logic             ovf,
`endif
    output logic             borrow
);
    localparam int N  = WIDTH / 4;
    localparam int KW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, res, res_n;
    logic             br;
    logic [KW-1:0]    k;
    logic [3:0]       na, nb, g, p, s;
    logic [4:0]       c;
    logic             last, accept;

    // Subtraction as A + ~B + ~borrow; carries are formed in parallel from G/P.
    always_comb begin
        na    = a_q[4*int'(k) +: 4];
        nb    = b_q[4*int'(k) +: 4];
        g     = na & ~nb;
        p     = na ^ ~nb;
        c[0]  = ~br;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s     = p ^ c[3:0];
        res_n = res;
        res_n[4*int'(k) +: 4] = s;
    end

    assign last   = k == KW'(N - 1);
    assign accept = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            res    <= '0;
            br     <= 1'b0;
            k      <= '0;
`ifdef SUB_STATUS_FLAGS_EN
            zero   <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            state <= accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
            busy  <= accept || (state == RUN && !last);
            done  <= state == RUN && last;
            if (accept) begin
                a_q <= A;
                b_q <= B;
                br  <= bin;
                k   <= '0;
                res <= '0;
            end else if (state == RUN) begin
                res <= res_n;
                br  <= ~c[4];
                k   <= k + 1'b1;
                if (last) begin
                    diff   <= res_n;
                    borrow <= ~c[4];
`ifdef SUB_STATUS_FLAGS_EN
                    zero   <= res_n == '0;
                    neg    <= res_n[WIDTH-1];
                    ovf    <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ res_n[WIDTH-1]);
`endif
                end
            end
        end
    end
endmodule
